// File: rtl/alu_issue_queue.sv
// alu_issue_queue: in-order issue stage in front of a combinational alu.
//   Requests {a,b,f} are buffered in a DEPTH-entry circular queue. The queue
//   head drives the alu operand/function ports. The alu's y/t are captured into
//   a result register that has a valid/ready output handshake.
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   in_valid/in_ready         request handshake; in_a, in_b, in_f request payload
//   alu_a/alu_b/alu_f         head of queue to the alu (0 when empty)
//   alu_y/alu_t               combinational alu result for the head
//   out_valid/out_ready       result handshake; out_y, out_t registered result
//   count                     queue occupancy 0..DEPTH
module alu_issue_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [2:0]               in_f,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_f,
  input  logic [WIDTH-1:0]         alu_y,
  input  logic [2:0]               alu_t,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_y,
  output logic [2:0]               out_t,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       f;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  req_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_y_q;
  logic [2:0]       out_t_q;
  logic             push, pop, nonempty;
  req_t             head;

  assign nonempty  = (cnt_q != '0);
  // No bypass: a full queue refuses input even when it pops this cycle.
  assign in_ready  = (cnt_q != FULL);
  assign push      = in_valid & in_ready;
  assign out_valid = (state_q != S_IDLE);
  assign pop       = nonempty & (~out_valid | out_ready);

  assign head  = nonempty ? mem_q[rd_q] : '0;
  assign alu_a = head.a;
  assign alu_b = head.b;
  assign alu_f = head.f;

  assign out_y = out_y_q;
  assign out_t = out_t_q;
  assign count = cnt_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Result slot state; out_valid is simply "not IDLE".
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pop) state_d = S_RUN;
      S_RUN: begin
        if (!out_ready) state_d = S_HOLD;
        else if (!pop)  state_d = S_IDLE;
      end
      S_HOLD: begin
        if (out_ready) state_d = pop ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      state_q <= S_IDLE;
      out_y_q <= '0;
      out_t_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      if (pop) begin
        out_y_q <= alu_y;
        out_t_q <= alu_t;
      end
    end
  end

  // Storage is not reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= '{a: in_a, b: in_b, f: in_f};
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural alu hooked to the
// alu_* ports.
module tb_alu_issue_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic [2:0]  in_f = '0;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [2:0]  alu_f, alu_t;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_y;
  logic [2:0]  out_t;
  logic [2:0]  count;

  int nchk = 0, nerr = 0;
  logic [34:0] expq[$];

  always #5 clk = ~clk;

  alu_issue_queue #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_f(in_f),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_y(alu_y), .alu_t(alu_t),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_t(out_t), .count(count)
  );

  // Reference alu: 0 sub/cmp, 1 add, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra.
  function automatic logic [34:0] alu_ref(input logic [31:0] a, b, input logic [2:0] f);
    logic [31:0] y;
    logic [2:0]  t;
    t = '0;
    case (f)
      3'd0: begin
        y = a - b;
        t = {a < b, $signed(a) < $signed(b), a == b};
      end
      3'd1: y = a + b;
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = a << b[4:0];
      3'd6: y = a >> b[4:0];
      default: y = 32'($signed(a) >>> b[4:0]);
    endcase
    return {y, t};
  endfunction

  assign {alu_y, alu_t} = alu_ref(alu_a, alu_b, alu_f);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request through an otherwise idle queue, consumer always ready.
  task automatic one(input string tag, input logic [31:0] a, b, input logic [2:0] f,
                     input logic [31:0] ey, input logic [2:0] et);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_a = a; in_b = b; in_f = f;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_cnt1"}, 64'(count), 64'd1);
    chk({tag, "_ov0"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_ov1"}, 64'(out_valid), 64'd1);
    chk({tag, "_y"}, 64'(out_y), 64'(ey));
    chk({tag, "_t"}, 64'(out_t), 64'(et));
    @(negedge clk);
    chk({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int acc, sent, got, cyc;
    logic seen;
    logic [34:0] e;
    logic [31:0] a, b;

    // 1: reset state, then a pulse while idle
    #1;
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_y", 64'(out_y), 64'd0);
    chk("rst_cnt", 64'(count), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_f", 64'(alu_f), 64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; #1;
    chk("idle_rst_ov", 64'(out_valid), 64'd0);
    chk("idle_rst_cnt", 64'(count), 64'd0);
    chk("idle_rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk); rst = 1'b0;

    // 2, 3: hand-computed single ops
    one("sub", 32'd5, 32'd3, 3'd0, 32'd2, 3'b000);
    one("add", 32'd5, 32'd3, 3'd1, 32'd8, 3'b000);
    one("neg", 32'hFFFFFFFF, 32'd1, 3'd0, 32'hFFFFFFFE, 3'b010);
    one("eq", 32'd7, 32'd7, 3'd0, 32'd0, 3'b001);

    // 4: fill with consumer stalled, then drain in order
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'(100 + i); in_b = 32'(i); in_f = 3'd1;
      #1 if (in_ready) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("fill_acc", 64'(acc), 64'd5);
    chk("fill_rdy", 64'(in_ready), 64'd0);
    chk("fill_cnt", 64'(count), 64'd4);
    chk("fill_ov", 64'(out_valid), 64'd1);
    chk("hold_head", 64'(alu_a), 64'd101);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("drain_ov", 64'(out_valid), 64'd1);
      chk("drain_y", 64'(out_y), 64'(100 + 2 * k));
      @(negedge clk);
    end
    chk("drain_end_ov", 64'(out_valid), 64'd0);
    chk("drain_end_cnt", 64'(count), 64'd0);

    // 5: back-to-back ops with random consumer stalls
    expq.delete(); sent = 0; got = 0; cyc = 0;
    while ((sent < 10 || got < 10) && cyc < 300) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 10) begin
        a = (sent % 2 == 1) ? 32'(-(sent * 37)) : 32'(sent * 1000 + 3);
        b = (sent % 3 == 0) ? a : 32'(sent + 2);
        in_valid = 1'b1; in_a = a; in_b = b; in_f = 3'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) begin
        expq.push_back(alu_ref(in_a, in_b, in_f));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("mix_extra", 64'(out_valid), 64'd0);
        end else begin
          e = expq.pop_front();
          chk("mix_y", 64'(out_y), 64'(e[34:3]));
          chk("mix_t", 64'(out_t), 64'(e[2:0]));
        end
        got++;
      end
    end
    in_valid = 1'b0;
    chk("mix_done", 64'(got), 64'd10);

    // 6: reset with work in flight
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'(i + 1); in_b = 32'd2; in_f = 3'd3;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_cnt", 64'(count), 64'd3);
    chk("pre_ov", 64'(out_valid), 64'd1);
    chk("pre_f", 64'(alu_f), 64'd3);
    rst = 1'b1; #1;
    chk("mid_rst_ov", 64'(out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(count), 64'd0);
    chk("mid_rst_y", 64'(out_y), 64'd0);
    chk("mid_rst_f", 64'(alu_f), 64'd0);
    chk("mid_rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1; seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("post_rst_stale", 64'(seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
